// File: rtl/integral_image_stream.sv
// integral_image_stream
// Streaming integral-image (summed-area table) generator. Each accepted
// pixel produces the sum of all pixels above and to the left of it in the
// current frame, including the pixel itself. One result is produced per
// accepted pixel, and the block sustains one pixel per cycle.
//
// Ports:
//   clock, reset        single clock; synchronous active-high reset
//   in_valid/in_ready   pixel handshake (in_ready = !out_valid || out_ready)
//   in_data [W-1:0]     unsigned pixel
//   in_sof              start of frame, qualified by in_valid
//   out_valid/out_ready result handshake; outputs stay stable while stalled
//   out_sum [W_SUM-1:0] integral value at the current pixel
//   out_eol, out_eof    last column of the row / last pixel of the frame
//   out_sqsum           integral of squared pixels (only with the macro)
//   sof_err             one-cycle pulse on a start-of-frame protocol error
//
// Build option: define INTEGRAL_IMAGE_SQUARE_EN to add the squared-integral
// path and its out_sqsum port.
module integral_image_stream #(
    parameter int W    = 8,
    parameter int COLS = 4,
    parameter int ROWS = 4,
    localparam int W_SUM = W + $clog2(COLS) + $clog2(ROWS)
`ifdef INTEGRAL_IMAGE_SQUARE_EN
    ,
    localparam int W_SQ = 2 * W + $clog2(COLS) + $clog2(ROWS)
`endif
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_data,
    input  logic             in_sof,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W_SUM-1:0] out_sum,
    output logic             out_eol,
    output logic             out_eof,
`ifdef INTEGRAL_IMAGE_SQUARE_EN
    output logic [W_SQ-1:0]  out_sqsum,
`endif
    output logic             sof_err
);

    localparam int CW = $clog2(COLS);
    localparam int RW = $clog2(ROWS);

    typedef enum logic {
        ST_WAIT_SOF = 1'b0,
        ST_ACTIVE   = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    col_q, col_d;
    logic [RW-1:0]    row_q, row_d;
    logic [W_SUM-1:0] row_acc_q, row_acc_d;
    logic             out_valid_q, out_valid_d;
    logic [W_SUM-1:0] out_sum_q, out_sum_d;
    logic             out_eol_q, out_eol_d;
    logic             out_eof_q, out_eof_d;
    logic             sof_err_q, sof_err_d;

    // Previous row's results; contents on row 0 are never used.
    logic [W_SUM-1:0] row_buf_q [COLS];

    logic             accept;
    logic             process;
    logic             buf_we;
    logic [CW-1:0]    eff_col;
    logic [RW-1:0]    eff_row;
    logic             last_col;
    logic             last_row;
    logic [W_SUM-1:0] pix_ext;
    logic [W_SUM-1:0] acc_new;
    logic [W_SUM-1:0] above;
    logic [W_SUM-1:0] sum_new;

`ifdef INTEGRAL_IMAGE_SQUARE_EN
    logic [W_SQ-1:0]  sq_acc_q, sq_acc_d;
    logic [W_SQ-1:0]  out_sq_q, out_sq_d;
    logic [W_SQ-1:0]  sq_buf_q [COLS];
    logic [2*W-1:0]   pix_sq;
    logic [W_SQ-1:0]  sq_acc_new;
    logic [W_SQ-1:0]  sq_above;
    logic [W_SQ-1:0]  sq_new;
`endif

    assign in_ready  = !out_valid_q || out_ready;
    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;
    assign out_eol   = out_eol_q;
    assign out_eof   = out_eof_q;
    assign sof_err   = sof_err_q;
`ifdef INTEGRAL_IMAGE_SQUARE_EN
    assign out_sqsum = out_sq_q;
`endif

    // Datapath for the pixel being accepted; a pixel with sof is always (0,0).
    always_comb begin
        accept   = in_valid && in_ready;
        process  = accept && (in_sof || (state_q == ST_ACTIVE));
        eff_col  = in_sof ? {CW{1'b0}} : col_q;
        eff_row  = in_sof ? {RW{1'b0}} : row_q;
        last_col = (eff_col == CW'(COLS - 1));
        last_row = (eff_row == RW'(ROWS - 1));
        pix_ext  = {{(W_SUM - W){1'b0}}, in_data};
        acc_new  = (eff_col == {CW{1'b0}}) ? pix_ext : (row_acc_q + pix_ext);
        above    = (eff_row == {RW{1'b0}}) ? {W_SUM{1'b0}} : row_buf_q[eff_col];
        sum_new  = acc_new + above;
`ifdef INTEGRAL_IMAGE_SQUARE_EN
        pix_sq     = (2 * W)'(in_data) * (2 * W)'(in_data);
        sq_acc_new = (eff_col == {CW{1'b0}}) ? {{(W_SQ - 2 * W){1'b0}}, pix_sq}
                                             : (sq_acc_q + {{(W_SQ - 2 * W){1'b0}}, pix_sq});
        sq_above   = (eff_row == {RW{1'b0}}) ? {W_SQ{1'b0}} : sq_buf_q[eff_col];
        sq_new     = sq_acc_new + sq_above;
`endif
    end

    // Next-state: frame position FSM, output register loading and hold.
    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        row_d       = row_q;
        row_acc_d   = row_acc_q;
        out_valid_d = out_valid_q && !out_ready;
        out_sum_d   = out_sum_q;
        out_eol_d   = out_eol_q;
        out_eof_d   = out_eof_q;
        buf_we      = 1'b0;
`ifdef INTEGRAL_IMAGE_SQUARE_EN
        sq_acc_d    = sq_acc_q;
        out_sq_d    = out_sq_q;
`endif
        // Error: data before any sof, or sof anywhere but (0,0) mid-frame.
        sof_err_d = accept && (((state_q == ST_WAIT_SOF) && !in_sof) ||
                               ((state_q == ST_ACTIVE) && in_sof &&
                                ((col_q != {CW{1'b0}}) || (row_q != {RW{1'b0}}))));
        if (process) begin
            row_acc_d   = acc_new;
            out_valid_d = 1'b1;
            out_sum_d   = sum_new;
            out_eol_d   = last_col;
            out_eof_d   = last_col && last_row;
            buf_we      = 1'b1;
`ifdef INTEGRAL_IMAGE_SQUARE_EN
            sq_acc_d    = sq_acc_new;
            out_sq_d    = sq_new;
`endif
            if (last_col && last_row) begin
                state_d = ST_WAIT_SOF;
                col_d   = {CW{1'b0}};
                row_d   = {RW{1'b0}};
            end else if (last_col) begin
                state_d = ST_ACTIVE;
                col_d   = {CW{1'b0}};
                row_d   = eff_row + RW'(1);
            end else begin
                state_d = ST_ACTIVE;
                col_d   = eff_col + CW'(1);
                row_d   = eff_row;
            end
        end else begin
            buf_we = 1'b0;
        end
    end

    // State and output registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_WAIT_SOF;
            col_q       <= {CW{1'b0}};
            row_q       <= {RW{1'b0}};
            row_acc_q   <= {W_SUM{1'b0}};
            out_valid_q <= 1'b0;
            out_sum_q   <= {W_SUM{1'b0}};
            out_eol_q   <= 1'b0;
            out_eof_q   <= 1'b0;
            sof_err_q   <= 1'b0;
`ifdef INTEGRAL_IMAGE_SQUARE_EN
            sq_acc_q    <= {W_SQ{1'b0}};
            out_sq_q    <= {W_SQ{1'b0}};
`endif
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            row_q       <= row_d;
            row_acc_q   <= row_acc_d;
            out_valid_q <= out_valid_d;
            out_sum_q   <= out_sum_d;
            out_eol_q   <= out_eol_d;
            out_eof_q   <= out_eof_d;
            sof_err_q   <= sof_err_d;
`ifdef INTEGRAL_IMAGE_SQUARE_EN
            sq_acc_q    <= sq_acc_d;
            out_sq_q    <= out_sq_d;
`endif
        end
    end

    // Row buffer: store this pixel's result for the pixel below it.
    always_ff @(posedge clock) begin
        if (buf_we) begin
            row_buf_q[eff_col] <= sum_new;
`ifdef INTEGRAL_IMAGE_SQUARE_EN
            sq_buf_q[eff_col]  <= sq_new;
`endif
        end
    end

endmodule

// File: tb/tb_integral_image_stream.sv
module tb_integral_image_stream;

    localparam int W     = 8;
    localparam int COLS  = 4;
    localparam int ROWS  = 4;
    localparam int W_SUM = 12;
    localparam int W_SQ  = 20;

    logic             clock = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     in_data;
    logic             in_sof;
    logic             out_valid;
    logic             out_ready;
    logic [W_SUM-1:0] out_sum;
    logic             out_eol;
    logic             out_eof;
    logic             sof_err;
`ifdef INTEGRAL_IMAGE_SQUARE_EN
    logic [W_SQ-1:0]  out_sqsum;
`endif

    always #5 clock = ~clock;

    integral_image_stream #(.W(W), .COLS(COLS), .ROWS(ROWS)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sof    (in_sof),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_eol   (out_eol),
        .out_eof   (out_eof),
`ifdef INTEGRAL_IMAGE_SQUARE_EN
        .out_sqsum (out_sqsum),
`endif
        .sof_err   (sof_err)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: frame image plus expected registered outputs.
    bit  m_valid, m_eol, m_eof, m_err, m_inframe;
    int  m_sum, m_sq, m_pos;
    int  img [ROWS][COLS];
    int  taken_cnt, last_sum, last_sq;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int integ(input int x, input int y, input bit sq);
        int s = 0;
        for (int yy = 0; yy <= y; yy++)
            for (int xx = 0; xx <= x; xx++)
                s += sq ? img[yy][xx] * img[yy][xx] : img[yy][xx];
        return s;
    endfunction

    task automatic model_reset();
        m_valid = 0; m_eol = 0; m_eof = 0; m_err = 0; m_inframe = 0;
        m_sum = 0; m_sq = 0; m_pos = 0;
    endtask

    // One clock cycle: drive, check against model, then advance the model.
    task automatic cycle(input bit v, input int d, input bit s, input bit rdy, output bit acc);
        int x, y;
        @(negedge clock);
        in_valid = v; in_data = d[7:0]; in_sof = s; out_ready = rdy;
        #1;
        chk("in_ready", in_ready, !m_valid || rdy);
        chk("out_valid", out_valid, m_valid);
        chk("sof_err", sof_err, m_err);
        if (m_valid) begin
            chk("out_sum", out_sum, m_sum);
            chk("out_eol", out_eol, m_eol);
            chk("out_eof", out_eof, m_eof);
`ifdef INTEGRAL_IMAGE_SQUARE_EN
            chk("out_sqsum", out_sqsum, m_sq);
`endif
        end
        acc = v && (!m_valid || rdy);
        if (m_valid && rdy) begin
            taken_cnt++;
            last_sum = int'(out_sum);
`ifdef INTEGRAL_IMAGE_SQUARE_EN
            last_sq = int'(out_sqsum);
`endif
            m_valid = 0;
        end
        m_err = 0;
        if (acc) begin
            if (s) begin
                if (m_inframe && m_pos != 0) m_err = 1;
                m_inframe = 1;
                m_pos = 0;
                foreach (img[i, j]) img[i][j] = 0;
            end else if (!m_inframe) begin
                m_err = 1;
            end
            if (m_inframe) begin
                x = m_pos % COLS;
                y = m_pos / COLS;
                img[y][x] = d;
                m_sum = integ(x, y, 1'b0);
                m_sq = integ(x, y, 1'b1);
                m_eol = (x == COLS - 1);
                m_eof = (m_pos == COLS * ROWS - 1);
                m_valid = 1;
                m_pos++;
                if (m_pos == COLS * ROWS) m_inframe = 0;
            end
        end
    endtask

    task automatic send(input int d, input bit s, input bit rnd);
        bit a = 0;
        int n = 0;
        while (!a && n < 50) begin
            cycle(1'b1, d, s, rnd ? 1'($urandom_range(0, 1)) : 1'b1, a);
            n++;
        end
        if (!a) chk("send_timeout", 64'd0, 64'd1);
    endtask

    task automatic drain();
        bit a;
        cycle(1'b0, 0, 1'b0, 1'b1, a);
        cycle(1'b0, 0, 1'b0, 1'b1, a);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1; in_valid = 0; in_sof = 0; in_data = '0; out_ready = 0;
        @(negedge clock);
        reset = 0;
        model_reset();
        #1;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_sum", out_sum, 0);
        chk("rst_out_eol", out_eol, 1'b0);
        chk("rst_out_eof", out_eof, 1'b0);
        chk("rst_sof_err", sof_err, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
`ifdef INTEGRAL_IMAGE_SQUARE_EN
        chk("rst_out_sqsum", out_sqsum, 0);
`endif
    endtask

    initial begin
        bit a;
        reset = 1; in_valid = 0; in_sof = 0; in_data = '0; out_ready = 0;
        model_reset();
        taken_cnt = 0; last_sum = 0; last_sq = 0;
        do_reset();

        // Frame of ones at full rate.
        taken_cnt = 0;
        for (int i = 0; i < 16; i++) send(1, i == 0, 1'b0);
        drain();
        chk("ones_count", taken_cnt, 16);
        chk("ones_last", last_sum, 16);

        // Saturated pixels: largest possible sums.
        for (int i = 0; i < 16; i++) send(255, i == 0, 1'b0);
        drain();
        chk("max_last", last_sum, 4080);
`ifdef INTEGRAL_IMAGE_SQUARE_EN
        chk("max_last_sq", last_sq, 1040400);
`endif

        // Downstream stall for three cycles mid-frame.
        taken_cnt = 0;
        for (int i = 0; i < 6; i++) send(1, i == 0, 1'b0);
        repeat (3) cycle(1'b1, 1, 1'b0, 1'b0, a);
        for (int i = 6; i < 16; i++) send(1, 1'b0, 1'b0);
        drain();
        chk("stall_count", taken_cnt, 16);
        chk("stall_last", last_sum, 16);

        // Pixels before any sof are dropped with an error, then a random frame.
        taken_cnt = 0;
        for (int i = 0; i < 3; i++) send(7, 1'b0, 1'b0);
        drain();
        chk("nosof_count", taken_cnt, 0);
        for (int i = 0; i < 16; i++) send(int'($urandom_range(0, 255)), i == 0, 1'b0);
        drain();
        chk("rand_frame_count", taken_cnt, 16);

        // Early sof on the sixth pixel restarts the frame.
        for (int i = 0; i < 5; i++) send(1, i == 0, 1'b0);
        send(1, 1'b1, 1'b0);
        for (int i = 1; i < 16; i++) send(1, 1'b0, 1'b0);
        drain();
        chk("restart_last", last_sum, 16);

        // Reset mid-frame, then a clean frame.
        for (int i = 0; i < 9; i++) send(1, i == 0, 1'b0);
        do_reset();
        taken_cnt = 0;
        for (int i = 0; i < 16; i++) send(1, i == 0, 1'b0);
        drain();
        chk("post_rst_count", taken_cnt, 16);
        chk("post_rst_last", last_sum, 16);

        // Random traffic with random back-pressure and occasional sof.
        for (int i = 0; i < 400; i++)
            cycle($urandom_range(0, 3) != 0, int'($urandom_range(0, 255)),
                  $urandom_range(0, 19) == 0, $urandom_range(0, 3) != 0, a);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
